// File: rtl/gc9a01_spi_receiver_if.sv
// gc9a01_spi_receiver_if: 4-wire GC9A01 SPI link bundle.
// Driver side is the master, panel side the slave.
interface gc9a01_spi_receiver_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_cs_n;
    logic lcd_dc;

    modport master (
        output spi_clk,
        output spi_mosi,
        output spi_cs_n,
        output lcd_dc
    );

    modport slave (
        input spi_clk,
        input spi_mosi,
        input spi_cs_n,
        input lcd_dc
    );
endinterface

// File: rtl/gc9a01_spi_receiver.sv
// gc9a01_spi_receiver: panel-side SPI byte assembler and
// CASET/RASET/RAMWR/RAMWRC decoder producing RGB565 pixel writes.
module gc9a01_spi_receiver #(
    parameter int SCREEN_WIDTH  = 240,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic                       clk,
    input  logic                       reset_n,
    gc9a01_spi_receiver_if.slave       spi,
    output logic                       byte_valid,
    output logic [7:0]                 byte_data,
    output logic                       byte_is_data,
    output logic                       cmd_valid,
    output logic [7:0]                 cmd_code,
    output logic                       pix_valid,
    output logic [15:0]                pix_data,
    output logic [15:0]                pix_x,
    output logic [15:0]                pix_y,
    output logic                       frame_done,
    output logic [15:0]                pixel_count
);

    typedef enum logic [2:0] {
        D_IDLE,
        D_CASET,
        D_RASET,
        D_RAMWR,
        D_IGNORE
    } dec_state_t;

    localparam logic [15:0] X_END_RST = 16'(SCREEN_WIDTH - 1);
    localparam logic [15:0] Y_END_RST = 16'(SCREEN_HEIGHT - 1);

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC = 8'h3C;

    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic [1:0] cs_sync;
    logic [1:0] dc_sync;
    logic       sck_dly;

    logic sck_rise;
    logic cs_n;
    logic mosi_s;
    logic dc_s;

    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic       byte_pend;

    dec_state_t state;
    dec_state_t state_n;

    logic [1:0]  arg_idx;
    logic [1:0]  arg_idx_n;
    logic [7:0]  arg0;
    logic [7:0]  arg0_n;
    logic [7:0]  arg1;
    logic [7:0]  arg1_n;
    logic [7:0]  arg2;
    logic [7:0]  arg2_n;
    logic        hi_have;
    logic        hi_have_n;
    logic [7:0]  hi_byte;
    logic [7:0]  hi_byte_n;

    logic [15:0] x_start;
    logic [15:0] x_start_n;
    logic [15:0] x_end;
    logic [15:0] x_end_n;
    logic [15:0] y_start;
    logic [15:0] y_start_n;
    logic [15:0] y_end;
    logic [15:0] y_end_n;
    logic [15:0] x_cur;
    logic [15:0] x_cur_n;
    logic [15:0] y_cur;
    logic [15:0] y_cur_n;

    logic        cmd_valid_n;
    logic [7:0]  cmd_code_n;
    logic        pix_valid_n;
    logic [15:0] pix_data_n;
    logic [15:0] pix_x_n;
    logic [15:0] pix_y_n;
    logic        frame_done_n;
    logic [15:0] pixel_count_n;

    // Equal-depth synchronisers keep clock, data, select and dc aligned.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            dc_sync   <= 2'b00;
            sck_dly   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi.spi_clk};
            mosi_sync <= {mosi_sync[0], spi.spi_mosi};
            cs_sync   <= {cs_sync[0], spi.spi_cs_n};
            dc_sync   <= {dc_sync[0], spi.lcd_dc};
            sck_dly   <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_dly;
    assign cs_n     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign dc_s     = dc_sync[1];

    // Shift MSB-first bits; a full byte is reported one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt      <= 3'd0;
            shift_reg    <= 7'd0;
            byte_pend    <= 1'b0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'd0;
            byte_is_data <= 1'b0;
        end else begin
            byte_valid <= byte_pend;
            byte_pend  <= 1'b0;
            if (cs_n) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 7'd0;
            end else if (sck_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_data    <= {shift_reg, mosi_s};
                    byte_is_data <= dc_s;
                    byte_pend    <= 1'b1;
                end
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= D_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Decoder next state, window/address update and pixel outputs.
    always_comb begin
        state_n       = state;
        arg_idx_n     = arg_idx;
        arg0_n        = arg0;
        arg1_n        = arg1;
        arg2_n        = arg2;
        hi_have_n     = hi_have;
        hi_byte_n     = hi_byte;
        x_start_n     = x_start;
        x_end_n       = x_end;
        y_start_n     = y_start;
        y_end_n       = y_end;
        x_cur_n       = x_cur;
        y_cur_n       = y_cur;
        cmd_valid_n   = 1'b0;
        cmd_code_n    = cmd_code;
        pix_valid_n   = 1'b0;
        pix_data_n    = pix_data;
        pix_x_n       = pix_x;
        pix_y_n       = pix_y;
        frame_done_n  = 1'b0;
        pixel_count_n = pixel_count;

        if (byte_pend && !byte_is_data) begin
            cmd_valid_n = 1'b1;
            cmd_code_n  = byte_data;
            arg_idx_n   = 2'd0;
            hi_have_n   = 1'b0;
            unique case (byte_data)
                CMD_CASET:  state_n = D_CASET;
                CMD_RASET:  state_n = D_RASET;
                CMD_RAMWR: begin
                    state_n       = D_RAMWR;
                    x_cur_n       = x_start;
                    y_cur_n       = y_start;
                    pixel_count_n = 16'd0;
                end
                CMD_RAMWRC: state_n = D_RAMWR;
                default:    state_n = D_IGNORE;
            endcase
        end else if (byte_pend) begin
            unique case (state)
                D_CASET, D_RASET: begin
                    arg_idx_n = arg_idx + 2'd1;
                    unique case (arg_idx)
                        2'd0: arg0_n = byte_data;
                        2'd1: arg1_n = byte_data;
                        2'd2: arg2_n = byte_data;
                        default: begin
                            if (state == D_CASET) begin
                                x_start_n = {arg0, arg1};
                                x_end_n   = {arg2, byte_data};
                            end else begin
                                y_start_n = {arg0, arg1};
                                y_end_n   = {arg2, byte_data};
                            end
                            state_n   = D_IGNORE;
                            arg_idx_n = 2'd0;
                        end
                    endcase
                end
                D_RAMWR: begin
                    if (!hi_have) begin
                        hi_have_n = 1'b1;
                        hi_byte_n = byte_data;
                    end else begin
                        hi_have_n    = 1'b0;
                        pix_valid_n  = 1'b1;
                        pix_data_n   = {hi_byte, byte_data};
                        pix_x_n      = x_cur;
                        pix_y_n      = y_cur;
                        frame_done_n = (x_cur == x_end) && (y_cur == y_end);
                        if (pixel_count != 16'hFFFF) begin
                            pixel_count_n = pixel_count + 16'd1;
                        end
                        if (x_cur == x_end) begin
                            x_cur_n = x_start;
                            if (y_cur == y_end) begin
                                y_cur_n = y_start;
                            end else begin
                                y_cur_n = y_cur + 16'd1;
                            end
                        end else begin
                            x_cur_n = x_cur + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end else if (cs_n) begin
            // Driver drops CS between bursts; an orphan high byte is stale.
            hi_have_n = 1'b0;
        end
    end

    // Decoder datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            arg_idx     <= 2'd0;
            arg0        <= 8'd0;
            arg1        <= 8'd0;
            arg2        <= 8'd0;
            hi_have     <= 1'b0;
            hi_byte     <= 8'd0;
            x_start     <= 16'd0;
            x_end       <= X_END_RST;
            y_start     <= 16'd0;
            y_end       <= Y_END_RST;
            x_cur       <= 16'd0;
            y_cur       <= 16'd0;
            cmd_valid   <= 1'b0;
            cmd_code    <= 8'd0;
            pix_valid   <= 1'b0;
            pix_data    <= 16'd0;
            pix_x       <= 16'd0;
            pix_y       <= 16'd0;
            frame_done  <= 1'b0;
            pixel_count <= 16'd0;
        end else begin
            arg_idx     <= arg_idx_n;
            arg0        <= arg0_n;
            arg1        <= arg1_n;
            arg2        <= arg2_n;
            hi_have     <= hi_have_n;
            hi_byte     <= hi_byte_n;
            x_start     <= x_start_n;
            x_end       <= x_end_n;
            y_start     <= y_start_n;
            y_end       <= y_end_n;
            x_cur       <= x_cur_n;
            y_cur       <= y_cur_n;
            cmd_valid   <= cmd_valid_n;
            cmd_code    <= cmd_code_n;
            pix_valid   <= pix_valid_n;
            pix_data    <= pix_data_n;
            pix_x       <= pix_x_n;
            pix_y       <= pix_y_n;
            frame_done  <= frame_done_n;
            pixel_count <= pixel_count_n;
        end
    end

endmodule

// File: tb/tb_gc9a01_spi_receiver.sv
// tb_gc9a01_spi_receiver: directed and random SPI traffic
// checked byte by byte against a window/address reference model.
module tb_gc9a01_spi_receiver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        frame_done;
    logic [15:0] pixel_count;

    gc9a01_spi_receiver_if bus ();

    gc9a01_spi_receiver #(
        .SCREEN_WIDTH(240),
        .SCREEN_HEIGHT(240)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .spi(bus),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_is_data(byte_is_data),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .frame_done(frame_done),
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Pulse counts observed on the pins, and the model's expectation.
    int n_cmd = 0;
    int n_pix = 0;
    int n_byte = 0;
    int m_cmds = 0;
    int m_pixs = 0;
    int m_bytes = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (cmd_valid) n_cmd++;
            if (pix_valid) n_pix++;
            if (byte_valid) n_byte++;
        end
    end

    // Reference model: panel memory window and write address.
    int          mode;
    logic [15:0] wxs, wxe, wys, wye, xc, yc, pc;
    logic [7:0]  a [4];
    int          argn;
    bit          hv;
    logic [7:0]  hb;
    logic [7:0]  mcmd;
    bit          e_cmdv, e_pixv, e_fd;
    logic [15:0] e_pix = 16'd0;
    logic [15:0] e_x = 16'd0;
    logic [15:0] e_y = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0;
        wxs = 16'd0;
        wxe = 16'd239;
        wys = 16'd0;
        wye = 16'd239;
        xc = 16'd0;
        yc = 16'd0;
        pc = 16'd0;
        argn = 0;
        hv = 0;
        hb = 8'd0;
        mcmd = 8'd0;
    endtask

    // mode: 0 idle, 1 column args, 2 row args, 3 memory write, 4 ignore
    task automatic model_byte(input bit dc, input logic [7:0] b);
        e_cmdv = 0;
        e_pixv = 0;
        e_fd = 0;
        m_bytes++;
        if (!dc) begin
            e_cmdv = 1;
            m_cmds++;
            mcmd = b;
            argn = 0;
            hv = 0;
            if (b == 8'h2A) mode = 1;
            else if (b == 8'h2B) mode = 2;
            else if (b == 8'h2C) begin
                mode = 3;
                xc = wxs;
                yc = wys;
                pc = 16'd0;
            end else if (b == 8'h3C) mode = 3;
            else mode = 4;
        end else if (mode == 1 || mode == 2) begin
            a[argn] = b;
            argn++;
            if (argn == 4) begin
                if (mode == 1) begin
                    wxs = {a[0], a[1]};
                    wxe = {a[2], a[3]};
                end else begin
                    wys = {a[0], a[1]};
                    wye = {a[2], a[3]};
                end
                mode = 4;
            end
        end else if (mode == 3) begin
            if (!hv) begin
                hv = 1;
                hb = b;
            end else begin
                hv = 0;
                e_pixv = 1;
                m_pixs++;
                e_pix = {hb, b};
                e_x = xc;
                e_y = yc;
                e_fd = (xc == wxe) && (yc == wye);
                if (pc != 16'hFFFF) pc = pc + 16'd1;
                if (xc == wxe) begin
                    xc = wxs;
                    yc = (yc == wye) ? wys : yc + 16'd1;
                end else begin
                    xc = xc + 16'd1;
                end
            end
        end
    endtask

    // One SPI bit, ~5 clk low then ~5 clk high; starts/ends just after posedge.
    task automatic spi_bit(input bit dc, input bit v);
        bus.spi_mosi = v;
        bus.lcd_dc = dc;
        bus.spi_cs_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.spi_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.spi_clk = 1'b0;
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b);
        bit          got;
        int          lat;
        logic [7:0]  o_bd;
        logic        o_bid, o_cv, o_pv, o_fd;
        logic [7:0]  o_cc;
        logic [15:0] o_pd, o_px, o_py, o_pc;
        got = 0;
        lat = 99;
        o_bd = 8'd0;
        o_bid = 1'b0;
        o_cv = 1'b0;
        o_pv = 1'b0;
        o_fd = 1'b0;
        o_cc = 8'd0;
        o_pd = 16'd0;
        o_px = 16'd0;
        o_py = 16'd0;
        o_pc = 16'd0;
        for (int i = 7; i >= 1; i--) spi_bit(dc, b[i]);
        bus.spi_mosi = b[0];
        bus.lcd_dc = dc;
        repeat (5) @(posedge clk);
        #1 bus.spi_clk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (byte_valid && !got) begin
                got = 1;
                lat = k;
                o_bd = byte_data;
                o_bid = byte_is_data;
                o_cv = cmd_valid;
                o_cc = cmd_code;
                o_pv = pix_valid;
                o_pd = pix_data;
                o_px = pix_x;
                o_py = pix_y;
                o_fd = frame_done;
                o_pc = pixel_count;
            end
        end
        bus.spi_clk = 1'b0;
        model_byte(dc, b);
        chk("byte_latency", lat, 4);
        chk("byte_data", o_bd, b);
        chk("byte_is_data", o_bid, dc);
        chk("cmd_valid", o_cv, e_cmdv);
        chk("cmd_code", o_cc, mcmd);
        chk("pix_valid", o_pv, e_pixv);
        chk("frame_done", o_fd, e_fd);
        chk("pixel_count", o_pc, pc);
        if (e_pixv) begin
            chk("pix_data", o_pd, e_pix);
            chk("pix_x", o_px, e_x);
            chk("pix_y", o_py, e_y);
        end
    endtask

    task automatic end_burst();
        @(posedge clk);
        #1 bus.spi_cs_n = 1'b1;
        bus.spi_clk = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        hv = 0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input int n,
                            input logic [31:0] args);
        send_byte(1'b0, c);
        for (int k = 0; k < n; k++) send_byte(1'b1, args[31-8*k -: 8]);
        end_burst();
    endtask

    task automatic send_pixels(input int n);
        for (int k = 0; k < 2 * n; k++) send_byte(1'b1, 8'($urandom));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        chk("rst_byte", {byte_valid, byte_is_data, byte_data}, 0);
        chk("rst_cmd", {cmd_valid, cmd_code}, 0);
        chk("rst_pix", {pix_valid, frame_done, pix_data}, 0);
        chk("rst_xy", {pix_x, pix_y}, 0);
        chk("rst_count", pixel_count, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] xs, ys, xw, yw;
        int np;
        bus.spi_clk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.lcd_dc = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        pulse_reset();

        send_cmd(8'h01, 0, 32'd0);

        send_cmd(8'h2A, 4, 32'h000A_000C);
        send_cmd(8'h2B, 4, 32'h0005_0006);
        send_byte(1'b0, 8'h2C);
        send_pixels(6);
        send_byte(1'b1, 8'hAB);
        send_byte(1'b1, 8'hCD);
        end_burst();

        pulse_reset();
        send_byte(1'b0, 8'h2C);
        send_pixels(3);
        end_burst();
        send_byte(1'b0, 8'h3C);
        send_pixels(1);
        end_burst();

        send_cmd(8'h2A, 4, 32'h0005_0010);
        send_cmd(8'h2A, 2, 32'h0020_0000);
        send_byte(1'b0, 8'h2C);
        send_pixels(2);
        end_burst();

        for (int i = 4; i >= 0; i--) spi_bit(1'b0, i[0]);
        end_burst();
        send_byte(1'b0, 8'h2C);
        end_burst();

        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h5A);
        pulse_reset();
        send_byte(1'b0, 8'h2C);
        send_pixels(2);
        end_burst();

        send_cmd(8'h2A, 4, 32'hFFFE_0001);
        send_cmd(8'h2B, 4, 32'h0000_0000);
        send_byte(1'b0, 8'h2C);
        send_pixels(5);
        end_burst();

        for (int it = 0; it < 8; it++) begin
            xs = 16'($urandom_range(0, 235));
            xw = 16'($urandom_range(0, 3));
            ys = 16'($urandom_range(0, 235));
            yw = 16'($urandom_range(0, 2));
            send_cmd(8'h2A, 4, {xs, xs + xw});
            send_cmd(8'h2B, 4, {ys, ys + yw});
            if ($urandom_range(0, 2) == 0)
                send_cmd(8'h36, 2, $urandom);
            send_byte(1'b0, (it % 3 == 2) ? 8'h3C : 8'h2C);
            np = $urandom_range(6, 20);
            for (int j = 0; j < np; j++) begin
                send_byte(1'b1, 8'($urandom));
                if ($urandom_range(0, 5) == 0) end_burst();
            end
            end_burst();
        end

        repeat (10) @(posedge clk);
        #1;
        chk("count_cmd", n_cmd, m_cmds);
        chk("count_pix", n_pix, m_pixs);
        chk("count_byte", n_byte, m_bytes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
